// File: rtl/tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor
//
// Passive watchdog on the eight lamp outputs of the traffic-light controller.
// It decodes the lamp pattern into a phase, measures how long each phase is
// held (dwell), and checks lamp conflicts, phase order and dwell length.
// Errors are reported as sticky flags plus a code for the first error seen.
// A counter records the number of completed legal cycles (VL -> HG).
//
// All outputs are registered. Inputs sampled at edge N show up after edge N.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Horizontal_*          horizontal lamps (Green, Yellow, Left, Red)
//   Vertical_*            vertical lamps (Green, Yellow, Left, Red)
//   clr_err               synchronous clear of error flags and first_err
//   phase                 registered decoded phase (also the tracker state)
//   err_conflict          sticky: illegal lamp combination seen
//   err_sequence          sticky: illegal phase transition seen
//   err_dwell             sticky: wrong phase duration seen
//   err_any               OR of the three error flags
//   first_err             00 none, 01 conflict, 10 sequence, 11 dwell
//   cycle_cnt             number of legal VL -> HG transitions (wraps)
// ---------------------------------------------------------------------------
module tlc_lamp_monitor #(
    parameter int GREEN_CYC  = 31,
    parameter int YELLOW_CYC = 6,
    parameter int LEFT_CYC   = 11,
    parameter int DWELL_W    = 8,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Horizontal_Green,
    input  logic             Horizontal_Yellow,
    input  logic             Horizontal_Left,
    input  logic             Horizontal_Red,
    input  logic             Vertical_Green,
    input  logic             Vertical_Yellow,
    input  logic             Vertical_Left,
    input  logic             Vertical_Red,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_dwell,
    output logic             err_any,
    output logic [1:0]       first_err,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        PH_DARK    = 3'b000,
        PH_HG      = 3'b001,
        PH_HY      = 3'b010,
        PH_HL      = 3'b011,
        PH_VG      = 3'b100,
        PH_VY      = 3'b101,
        PH_VL      = 3'b110,
        PH_ILLEGAL = 3'b111
    } phase_e;

    // Registered phase doubles as "prev": it only ever changes to cur, so the
    // previously held phase and the reported phase are the same value.
    phase_e             cur;
    phase_e             phase_q, phase_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dwell_valid_q, dwell_valid_d;
    logic               err_conflict_q, err_conflict_d;
    logic               err_sequence_q, err_sequence_d;
    logic               err_dwell_q, err_dwell_d;
    logic [1:0]         first_err_q, first_err_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic               ev_conflict;
    logic               ev_sequence;
    logic               ev_dwell;
    logic               legal_step;

    function automatic logic is_lamp(input phase_e p);
        return (p != PH_DARK) && (p != PH_ILLEGAL);
    endfunction

    function automatic phase_e successor(input phase_e p);
        phase_e s;
        case (p)
            PH_HG:   s = PH_HY;
            PH_HY:   s = PH_HL;
            PH_HL:   s = PH_VG;
            PH_VG:   s = PH_VY;
            PH_VY:   s = PH_VL;
            PH_VL:   s = PH_HG;
            default: s = PH_ILLEGAL;
        endcase
        return s;
    endfunction

    function automatic logic [DWELL_W-1:0] required_dwell(input phase_e p);
        logic [DWELL_W-1:0] r;
        case (p)
            PH_HG, PH_VG: r = DWELL_W'(GREEN_CYC);
            PH_HY, PH_VY: r = DWELL_W'(YELLOW_CYC);
            PH_HL, PH_VL: r = DWELL_W'(LEFT_CYC);
            default:      r = '0;
        endcase
        return r;
    endfunction

    // Lamp pattern decode, bit order {HG,HY,HL,HR,VG,VY,VL,VR}.
    always_comb begin
        cur = PH_ILLEGAL;
        case ({Horizontal_Green, Horizontal_Yellow, Horizontal_Left, Horizontal_Red,
               Vertical_Green, Vertical_Yellow, Vertical_Left, Vertical_Red})
            8'b0000_0000: cur = PH_DARK;
            8'b1000_0001: cur = PH_HG;
            8'b0100_0001: cur = PH_HY;
            8'b0010_0001: cur = PH_HL;
            8'b0001_1000: cur = PH_VG;
            8'b0001_0100: cur = PH_VY;
            8'b0001_0010: cur = PH_VL;
            default:      cur = PH_ILLEGAL;
        endcase
    end

    always_comb begin
        phase_d        = cur;
        dwell_d        = dwell_q;
        dwell_valid_d  = dwell_valid_q;
        cycle_cnt_d    = cycle_cnt_q;
        err_conflict_d = err_conflict_q;
        err_sequence_d = err_sequence_q;
        err_dwell_d    = err_dwell_q;
        first_err_d    = first_err_q;
        ev_conflict    = (cur == PH_ILLEGAL);
        ev_sequence    = 1'b0;
        ev_dwell       = 1'b0;
        legal_step     = 1'b0;

        if (cur == phase_q) begin
            // Saturate so a very long hold cannot wrap back to a legal value.
            if (dwell_q != '1) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end else begin
            dwell_d    = DWELL_W'(1);
            legal_step = is_lamp(phase_q) && (cur == successor(phase_q));

            if (is_lamp(phase_q) && is_lamp(cur) && !legal_step) begin
                ev_sequence = 1'b1;
            end
            if (is_lamp(phase_q) && (cur == PH_DARK)) begin
                ev_sequence = 1'b1;
            end
            if ((phase_q == PH_DARK) && is_lamp(cur) && (cur != PH_HG)) begin
                ev_sequence = 1'b1;
            end

            // Only phases entered by a legal step have a trustworthy dwell.
            if (dwell_valid_q && (dwell_q != required_dwell(phase_q))) begin
                ev_dwell = 1'b1;
            end
            dwell_valid_d = legal_step;

            if ((phase_q == PH_VL) && (cur == PH_HG)) begin
                cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
            end
        end

        if (clr_err) begin
            // Clear wins over any error event in the same cycle.
            err_conflict_d = 1'b0;
            err_sequence_d = 1'b0;
            err_dwell_d    = 1'b0;
            first_err_d    = 2'b00;
        end else begin
            err_conflict_d = err_conflict_q | ev_conflict;
            err_sequence_d = err_sequence_q | ev_sequence;
            err_dwell_d    = err_dwell_q | ev_dwell;
            if (first_err_q == 2'b00) begin
                if (ev_conflict) begin
                    first_err_d = 2'b01;
                end else if (ev_sequence) begin
                    first_err_d = 2'b10;
                end else if (ev_dwell) begin
                    first_err_d = 2'b11;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= PH_DARK;
            dwell_q        <= '0;
            dwell_valid_q  <= 1'b0;
            err_conflict_q <= 1'b0;
            err_sequence_q <= 1'b0;
            err_dwell_q    <= 1'b0;
            first_err_q    <= 2'b00;
            cycle_cnt_q    <= '0;
        end else begin
            phase_q        <= phase_d;
            dwell_q        <= dwell_d;
            dwell_valid_q  <= dwell_valid_d;
            err_conflict_q <= err_conflict_d;
            err_sequence_q <= err_sequence_d;
            err_dwell_q    <= err_dwell_d;
            first_err_q    <= first_err_d;
            cycle_cnt_q    <= cycle_cnt_d;
        end
    end

    assign phase        = phase_q;
    assign err_conflict = err_conflict_q;
    assign err_sequence = err_sequence_q;
    assign err_dwell    = err_dwell_q;
    assign err_any      = err_conflict_q | err_sequence_q | err_dwell_q;
    assign first_err    = first_err_q;
    assign cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_lamp_monitor
//
// Directed bench for tlc_lamp_monitor. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that took
// the sample. A second instance with short dwells and a 4-bit cycle counter
// exercises counter wrap.
//
// Flag vector used in checks: {err_conflict, err_sequence, err_dwell,
// err_any, first_err[1:0]}.
// ---------------------------------------------------------------------------
module tb_tlc_lamp_monitor;

    localparam logic [7:0] L_DARK = 8'b0000_0000;
    localparam logic [7:0] L_HG   = 8'b1000_0001;
    localparam logic [7:0] L_HY   = 8'b0100_0001;
    localparam logic [7:0] L_HL   = 8'b0010_0001;
    localparam logic [7:0] L_VG   = 8'b0001_1000;
    localparam logic [7:0] L_VY   = 8'b0001_0100;
    localparam logic [7:0] L_VL   = 8'b0001_0010;
    localparam logic [7:0] L_BAD  = 8'b1000_1001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [7:0]  lamps;
    logic        clr_err;
    logic [2:0]  phase;
    logic        err_conflict, err_sequence, err_dwell, err_any;
    logic [1:0]  first_err;
    logic [15:0] cycle_cnt;
    logic [5:0]  flags;

    tlc_lamp_monitor u_dut (
        .clk               (clk),
        .reset             (reset),
        .Horizontal_Green  (lamps[7]),
        .Horizontal_Yellow (lamps[6]),
        .Horizontal_Left   (lamps[5]),
        .Horizontal_Red    (lamps[4]),
        .Vertical_Green    (lamps[3]),
        .Vertical_Yellow   (lamps[2]),
        .Vertical_Left     (lamps[1]),
        .Vertical_Red      (lamps[0]),
        .clr_err           (clr_err),
        .phase             (phase),
        .err_conflict      (err_conflict),
        .err_sequence      (err_sequence),
        .err_dwell         (err_dwell),
        .err_any           (err_any),
        .first_err         (first_err),
        .cycle_cnt         (cycle_cnt)
    );

    assign flags = {err_conflict, err_sequence, err_dwell, err_any, first_err};

    // ---------------- short-dwell, narrow-counter DUT ----------------
    logic [7:0] w_lamps;
    logic       w_clr;
    logic [2:0] w_phase;
    logic       w_conflict, w_sequence, w_dwell, w_any;
    logic [1:0] w_first;
    logic [3:0] w_cycle_cnt;
    logic [5:0] w_flags;

    tlc_lamp_monitor #(
        .GREEN_CYC  (2),
        .YELLOW_CYC (1),
        .LEFT_CYC   (1),
        .DWELL_W    (8),
        .CYC_W      (4)
    ) u_wrap (
        .clk               (clk),
        .reset             (reset),
        .Horizontal_Green  (w_lamps[7]),
        .Horizontal_Yellow (w_lamps[6]),
        .Horizontal_Left   (w_lamps[5]),
        .Horizontal_Red    (w_lamps[4]),
        .Vertical_Green    (w_lamps[3]),
        .Vertical_Yellow   (w_lamps[2]),
        .Vertical_Left     (w_lamps[1]),
        .Vertical_Red      (w_lamps[0]),
        .clr_err           (w_clr),
        .phase             (w_phase),
        .err_conflict      (w_conflict),
        .err_sequence      (w_sequence),
        .err_dwell         (w_dwell),
        .err_any           (w_any),
        .first_err         (w_first),
        .cycle_cnt         (w_cycle_cnt)
    );

    assign w_flags = {w_conflict, w_sequence, w_dwell, w_any, w_first};

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [7:0] pat, input int n);
        lamps = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_w(input logic [7:0] pat, input int n);
        w_lamps = pat;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset   = 1'b1;
        lamps   = L_DARK;
        w_lamps = L_DARK;
        clr_err = 1'b0;
        w_clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_phase", 32'(phase), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_cycle", 32'(cycle_cnt), 32'd0);
        check("rst_wcycle", 32'(w_cycle_cnt), 32'd0);

        // Nominal run
        drive(L_DARK, 1);
        check("nom_dark", 32'(phase), 32'd0);
        drive(L_HG, 1);
        check("nom_hg_lag", 32'(phase), 32'd1);
        drive(L_HG, 29);
        drive(L_HY, 1);
        check("nom_hy", 32'(phase), 32'd2);
        drive(L_HY, 5);
        drive(L_HL, 11);
        drive(L_VG, 31);
        drive(L_VY, 6);
        drive(L_VL, 11);
        check("nom_vl", 32'(phase), 32'd6);
        check("nom_cyc0", 32'(cycle_cnt), 32'd0);
        drive(L_HG, 1);
        check("nom_cyc1", 32'(cycle_cnt), 32'd1);
        check("nom_flags_a", 32'(flags), 32'd0);
        drive(L_HG, 30);
        drive(L_HY, 6);
        drive(L_HL, 11);
        check("nom_hl", 32'(phase), 32'd3);
        check("nom_flags_b", 32'(flags), 32'd0);

        // Dwell error: HG held 30 after a legal entry
        drive(L_VG, 31);
        drive(L_VY, 6);
        drive(L_VL, 11);
        drive(L_HG, 30);
        drive(L_HY, 1);
        check("dwell_flags", 32'(flags), 32'(6'b001111));
        check("dwell_cyc", 32'(cycle_cnt), 32'd2);

        // Clear
        clr_err = 1'b1;
        drive(L_HY, 1);
        clr_err = 1'b0;
        check("clr_flags", 32'(flags), 32'd0);
        check("clr_cyc", 32'(cycle_cnt), 32'd2);
        check("clr_phase", 32'(phase), 32'd2);

        // Sequence error: HG 31 then VG
        drive(L_HY, 4);
        drive(L_HL, 11);
        drive(L_VG, 31);
        drive(L_VY, 6);
        drive(L_VL, 11);
        drive(L_HG, 31);
        check("seq_pre", 32'(flags), 32'd0);
        check("seq_cyc", 32'(cycle_cnt), 32'd3);
        drive(L_VG, 1);
        check("seq_flags", 32'(flags), 32'(6'b010110));
        drive(L_VG, 5);
        drive(L_VY, 1);
        check("seq_vg_nodwell", 32'(flags), 32'(6'b010110));

        clr_err = 1'b1;
        drive(L_VY, 1);
        clr_err = 1'b0;
        check("clr2_flags", 32'(flags), 32'd0);

        // Conflict during HG (short HG exit also raises dwell)
        drive(L_VY, 4);
        drive(L_VL, 11);
        drive(L_HG, 10);
        drive(L_BAD, 1);
        check("conf_flags", 32'(flags), 32'(6'b101101));
        check("conf_phase", 32'(phase), 32'd7);
        check("conf_cyc", 32'(cycle_cnt), 32'd4);

        // Clear wins over a conflict in the same cycle
        clr_err = 1'b1;
        drive(L_BAD, 1);
        clr_err = 1'b0;
        check("clrwin_flags", 32'(flags), 32'd0);

        // ILLEGAL -> DARK: no sequence check; DARK -> HY: sequence error
        drive(L_DARK, 2);
        check("ill_dark", 32'(flags), 32'd0);
        drive(L_HY, 1);
        check("dark_hy", 32'(flags), 32'(6'b010110));

        // Reset mid-VG, then HG entry from DARK
        drive(L_HY, 5);
        drive(L_HL, 11);
        drive(L_VG, 10);
        reset = 1'b1;
        drive(L_VG, 1);
        reset = 1'b0;
        check("mrst_phase", 32'(phase), 32'd0);
        check("mrst_flags", 32'(flags), 32'd0);
        check("mrst_cyc", 32'(cycle_cnt), 32'd0);
        drive(L_HG, 1);
        check("mrst_hg", 32'(phase), 32'd1);
        check("mrst_hg_flags", 32'(flags), 32'd0);
        drive(L_HG, 4);
        drive(L_HY, 1);
        check("mrst_nodwell", 32'(flags), 32'd0);

        // Saturation: HG held 300 after a legal entry
        drive(L_HY, 5);
        drive(L_HL, 11);
        drive(L_VG, 31);
        drive(L_VY, 6);
        drive(L_VL, 11);
        drive(L_HG, 300);
        check("sat_hold", 32'(flags), 32'd0);
        check("sat_cyc", 32'(cycle_cnt), 32'd1);
        drive(L_HY, 1);
        check("sat_exit", 32'(flags), 32'(6'b001111));

        // Counter wrap on the narrow instance (still DARK since reset)
        drive_w(L_HG, 2);
        for (int k = 1; k <= 16; k++) begin
            drive_w(L_HY, 1);
            drive_w(L_HL, 1);
            drive_w(L_VG, 2);
            drive_w(L_VY, 1);
            drive_w(L_VL, 1);
            drive_w(L_HG, 1);
            check("wrap_cnt", 32'(w_cycle_cnt), 32'(k % 16));
            drive_w(L_HG, 1);
        end
        check("wrap_flags", 32'(w_flags), 32'd0);
        check("wrap_phase", 32'(w_phase), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_lamp_monitor.md
Name: tlc_lamp_monitor

Overview:
- Passive checker on the eight lamp outputs of the traffic-light controller, at the consuming end of the lamp interface.
- Decodes the lamp pattern into a phase and measures how long each phase is held (dwell).
- Checks lamp conflicts, phase order and dwell lengths. Reports sticky error flags, the first error seen, and a count of completed full cycles.
- Sits beside the controller in the same clock domain. Used in silicon as a safety watchdog and in simulation as a scoreboard.

Parameters:
- GREEN_CYC, 31, required dwell in cycles for HG and VG.
- YELLOW_CYC, 6, required dwell in cycles for HY and VY.
- LEFT_CYC, 11, required dwell in cycles for HL and VL.
- DWELL_W, 8, dwell counter width; the counter saturates at all-ones.
- CYC_W, 16, completed-cycle counter width; the counter wraps.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Horizontal_Green  in  1  lamp
- Horizontal_Yellow  in  1  lamp
- Horizontal_Left  in  1  lamp
- Horizontal_Red  in  1  lamp
- Vertical_Green  in  1  lamp
- Vertical_Yellow  in  1  lamp
- Vertical_Left  in  1  lamp
- Vertical_Red  in  1  lamp
- clr_err  in  1  synchronous clear of error flags and first_err
- phase  out  3  registered decoded phase
- err_conflict  out  1  sticky: illegal lamp combination seen
- err_sequence  out  1  sticky: illegal phase transition seen
- err_dwell  out  1  sticky: wrong phase duration seen
- err_any  out  1  OR of the three error flags
- first_err  out  2  first error since reset/clear: 00 none, 01 conflict, 10 sequence, 11 dwell
- cycle_cnt  out  CYC_W  number of legal VL->HG transitions

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, port name reset; it is sampled on the rising edge of clk.
- Reset values: phase=000, every error flag=0, first_err=00, cycle_cnt=0, dwell=0, dwell_valid=0, prev=DARK.
- Reset mid-operation: a monitor reset while lamps are active leaves prev=DARK. The next non-DARK phase is checked as an entry from DARK.
- Phase decode, combinational on the inputs: cur phase values:
  - DARK (000): all lamps 0.
  - HG (001): HGreen and VRed only.
  - HY (010): HYellow and VRed only.
  - HL (011): HLeft and VRed only.
  - VG (100): VGreen and HRed only.
  - VY (101): VYellow and HRed only.
  - VL (110): VLeft and HRed only.
  - ILLEGAL (111): any other pattern.
- Legal successor order: HG->HY->HL->VG->VY->VL->HG.
- Latency: inputs are sampled at edge N. phase, flags, first_err and cycle_cnt reflect that sample after edge N (1-cycle latency).
- Per-cycle rules, evaluated on cur vs prev:
  - cur==ILLEGAL on any cycle: set err_conflict.
  - cur==prev: dwell = dwell+1, saturating at 2^DWELL_W-1.
  - cur!=prev (transition): dwell<=1, prev<=cur, then:
    - prev is a lamp phase (HG..VL), cur is a lamp phase: cur must equal successor(prev), else set err_sequence.
    - prev is a lamp phase, cur==DARK: set err_sequence.
    - prev==DARK, cur is a lamp phase: cur must be HG, else set err_sequence.
    - prev==ILLEGAL, or cur==ILLEGAL: no sequence check.
    - If dwell_valid=1: dwell must equal the required dwell for prev, else set err_dwell.
    - dwell_valid is set to 1 only when prev is a lamp phase and cur==successor(prev); otherwise dwell_valid=0.
    - Consequence: the first phase after DARK, and any phase entered illegally, is not dwell-checked.
  - Legal VL->HG: cycle_cnt+1, wrapping at 2^CYC_W.
- first_err:
  - Latched only while it is 00.
  - If several errors occur in the same cycle, priority is conflict > sequence > dwell.
- clr_err:
  - Clears the three flags and first_err at the next edge.
  - Error events in that same cycle are dropped; clear wins.
  - Does not touch phase, dwell or cycle_cnt.
  - reset has priority over clr_err.
- A phase held past saturation is not a failure by itself. On exit the saturated dwell still mismatches the required value, so err_dwell sets if dwell_valid=1.
- No output depends combinationally on the inputs.

Test Plan:
- Nominal run: reset, then DARK 1 cycle, HG 30, HY 6, HL 11, VG 31, VY 6, VL 11, HG 31, HY 6, HL 11. Required: all error flags 0; cycle_cnt=1 after the VL->HG transition; phase tracks the lamps 1 cycle late.
- Dwell error: legal entry into HG (after VL), hold HG 30 cycles, then HY. Required: err_dwell=1, first_err=11, err_sequence=0.
- Sequence error: HG 31 cycles then directly VG. Required: err_sequence=1, first_err=10, no dwell error on that exit (HG dwell correct), VG not dwell-checked.
- Simultaneous errors: during HG, assert Horizontal_Green and Vertical_Green together for 1 cycle; during a clean run, drive DARK->HY. Required:
  - ILLEGAL cycle: err_conflict=1 and first_err=01. The HG exit in that cycle also sets err_dwell, and first_err stays 01 by priority.
  - DARK->HY: err_sequence=1.
- Clear and reset: assert clr_err for 1 cycle, then check; assert reset mid-VG, release, drive HG. Required:
  - After clr_err: all flags and first_err=00, cycle_cnt unchanged.
  - After reset: cycle_cnt=0, phase=000; the HG entry is accepted without a dwell check.
- Saturation and wrap: hold HG for 300 cycles after a legal entry, then HY. Required: dwell stops at 255 and err_dwell=1. Force 65536 legal cycles (shorten the dwell parameters). Required: cycle_cnt wraps to 0.
